ex_issue_buffer: RTL and testbench
==================================

# ex_issue_buffer

Receiving end of the F/D pipeline handshake. It sits at the input of the execute stage, produces `FD_pipeready_o` toward `DF_Stage`, and absorbs decoded instruction bundles in a small skid FIFO. It presents the oldest bundle to the execute datapath with a valid/ready handshake. It also models iterative M-extension latency by withholding `ex_valid_o` for a fixed number of cycles, and it drops all buffered work on a flush.

## Interface
- `DEPTH`, 2, number of buffered bundles; must be at least 2.
- `MDIV_LAT`, 4, execute occupancy in cycles of an M-extension instruction; must be at least 1.
- `clk_i`  in  1  clock, rising edge.
- `reset_i`  in  1  reset; one clock, asynchronous and active-high.
- `fd_valid_i`  in  1  upstream bundle valid.
- `fd_pc_i`  in  32  upstream PC.
- `fd_instr_i`  in  32  upstream instruction word.
- `FD_pipeready_o`  out  1  registered ready to upstream.
- `ex_flush_i`  in  1  branch/exception flush; discards all buffered bundles.
- `ex_ready_i`  in  1  execute datapath can take the head bundle.
- `ex_valid_o`  out  1  head bundle valid and not held.
- `ex_pc_o`  out  32  head PC.
- `ex_instr_o`  out  32  head instruction.

## Operation
- Upstream accept: `fd_valid_i && FD_pipeready_o` at a rising edge. The bundle is written at the tail.
- Downstream pop: `ex_valid_o && ex_ready_i` at a rising edge. The head is removed.
- Accept and pop may occur in the same cycle. In that case the count is unchanged and the order is preserved.
- `count` has width `$clog2(DEPTH+1)`. Read and write pointers wrap modulo `DEPTH`.
- `FD_pipeready_o` is updated each edge to `count_next != DEPTH`, so it is never high while the FIFO is full.
- M-extension detection: the instruction has opcode `7'b0110011` and funct7 `7'b0000001`.
- Hold counter `hold_cnt` loads `MDIV_LAT-1` whenever an M-ext bundle becomes head. This happens in two cases:
  - it is written into an empty FIFO;
  - the previous head pops and the M-ext bundle moves up.
- Otherwise `hold_cnt` decrements while nonzero.
- `ex_valid_o = (count != 0) && (hold_cnt == 0)`.
- States are derived from `count`: EMPTY (0), PARTIAL (0 < count < DEPTH), FULL (DEPTH).
  - EMPTY→PARTIAL on accept without pop.
  - PARTIAL→FULL on accept without pop when count = DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without accept when count = 1.
  - Any state→EMPTY on flush.
- Flush has priority over accept and pop in the same cycle. After flush: `count` = 0, pointers = 0, `hold_cnt` = 0. The accepted bundle and the popped bundle are both discarded. `FD_pipeready_o` is 1 after the flush edge.
- `ex_pc_o` and `ex_instr_o` show the head entry whenever `count != 0`, even while the head is held. Their value is don't-care when `count` = 0; the implementation drives 0.

## Timing
- Reset values:
  - `FD_pipeready_o` = 0, `ex_valid_o` = 0, `ex_pc_o` = 0, `ex_instr_o` = 0.
  - `count`, pointers and `hold_cnt` = 0.
- `FD_pipeready_o` rises at the first clock edge after `reset_i` deasserts.
- Latency, non-M bundle accepted into EMPTY at edge N: `ex_valid_o` is high in the cycle after N.
- Latency, M-ext bundle accepted into EMPTY at edge N: `ex_valid_o` rises after edge N+MDIV_LAT-1.
- Throughput: one bundle per cycle with no bubbles while `ex_ready_i` = 1 and no M-ext instruction is in flight.
- Backpressure: `ex_ready_i` low with continuous upstream valid fills the FIFO. `FD_pipeready_o` falls at the edge where `count_next` reaches DEPTH.
- Popping from FULL restores `FD_pipeready_o` = 1 at that same edge. No data is lost or duplicated.
- Reset asserted mid-operation: all state clears immediately (asynchronous). No partial bundle is ever presented.

## Structure
- Shared package `pipe_pkg` holds:
  - constants `OP_REG = 7'b0110011` and `FUNCT7_MULDIV = 7'b0000001`;
  - `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fd_bundle_t`.
- Single module, no sub-module. Storage is an array of `fd_bundle_t` with registered read and write pointers.
- The M-ext detect function lives in `pipe_pkg` (`is_muldiv`) so that decode can reuse it.

## Test plan
- Reset release with `fd_valid_i` = 1 and PC = 0x0000_0000 → `FD_pipeready_o` = 0 during reset and 1 one edge after release. PC 0x0 appears on `ex_pc_o` with `ex_valid_o` = 1 the cycle after the accept.
- Stream PCs 0x00, 0x04, 0x08, 0x0C with `ex_ready_i` = 1 → four consecutive `ex_valid_o` cycles carrying those PCs in order, no gaps.
- Hold `ex_ready_i` = 0 while streaming → `FD_pipeready_o` falls after 2 accepts (PCs 0x00, 0x04). Then release `ex_ready_i` → 0x00, 0x04, 0x08 emerge in order with no duplicates.
- Issue `0x02B50533` (mul) at PC 0x10, then `0x00000013` (nop) → `ex_valid_o` is low for 3 cycles, then 0x10 pops, then 0x14 follows the next cycle.
- Fill FIFO to FULL, then assert `ex_flush_i` together with an upstream accept → next cycle `ex_valid_o` = 0 and `FD_pipeready_o` = 1. The next accepted PC 0x40 is the first output.
- Assert `reset_i` mid-hold with an M-ext instruction at head → outputs and `FD_pipeready_o` go to 0 asynchronously. After release, normal operation resumes with no stale bundle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared F/D pipeline definitions: opcode constants, the decoded bundle
// layout and the M-extension detector that decode and execute both use.
package pipe_pkg;

   localparam logic [6:0] OP_REG        = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fd_bundle_t;

   // Takes only the opcode and funct7 fields so callers never carry unused bits.
   function automatic logic is_muldiv(input logic [6:0] opcode,
                                      input logic [6:0] funct7);
      return (opcode == OP_REG) && (funct7 == FUNCT7_MULDIV);
   endfunction

endpackage

// File: rtl/ex_issue_buffer.sv
// Execute-stage input skid FIFO: registered ready toward DF_Stage, valid/ready
// issue of the oldest bundle, fixed M-extension occupancy hold, and flush.
module ex_issue_buffer
   import pipe_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MDIV_LAT = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        fd_valid_i,
   input  logic [31:0] fd_pc_i,
   input  logic [31:0] fd_instr_i,
   output logic        FD_pipeready_o,
   input  logic        ex_flush_i,
   input  logic        ex_ready_i,
   output logic        ex_valid_o,
   output logic [31:0] ex_pc_o,
   output logic [31:0] ex_instr_o
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int HOLD_W = (MDIV_LAT > 1) ? $clog2(MDIV_LAT) : 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MDIV_LAT - 1);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   if (DEPTH < 2) begin : g_depth_check
      $error("ex_issue_buffer: DEPTH must be at least 2");
   end
   if (MDIV_LAT < 1) begin : g_lat_check
      $error("ex_issue_buffer: MDIV_LAT must be at least 1");
   end

   fd_bundle_t        mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              ready_q, ready_d;

   logic [1:0]        state_q, state_d;
   logic [PTR_W-1:0]  rd_ptr_inc;
   logic [PTR_W-1:0]  wr_ptr_inc;
   fd_bundle_t        head;
   fd_bundle_t        next_head;
   logic              accept;
   logic              pop;
   logic              valid_int;
   logic              in_is_m;
   logic              next_is_m;
   logic              load_hold;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [1:0] state_of(input logic [CNT_W-1:0] c);
      if (c == '0) begin
         return ST_EMPTY;
      end else if (c == CNT_FULL) begin
         return ST_FULL;
      end else begin
         return ST_PARTIAL;
      end
   endfunction

   always_comb begin
      state_q    = state_of(count_q);
      rd_ptr_inc = ptr_inc(rd_ptr_q);
      wr_ptr_inc = ptr_inc(wr_ptr_q);
      head       = mem_q[rd_ptr_q];
      next_head  = mem_q[rd_ptr_inc];
      valid_int  = (state_q != ST_EMPTY) && (hold_q == '0);
      accept     = fd_valid_i && ready_q;
      pop        = valid_int && ex_ready_i;
      in_is_m    = is_muldiv(fd_instr_i[6:0], fd_instr_i[31:25]);
      next_is_m  = is_muldiv(next_head.instr[6:0], next_head.instr[31:25]);
   end

   // An M-ext bundle reaching the head arms the hold: either it lands in an
   // empty FIFO, or the old head pops and it moves up (from storage or bypassing in).
   always_comb begin
      load_hold = 1'b0;
      if (accept && (state_q == ST_EMPTY) && in_is_m) begin
         load_hold = 1'b1;
      end else if (pop && (count_q > CNT_ONE) && next_is_m) begin
         load_hold = 1'b1;
      end else if (pop && (count_q == CNT_ONE) && accept && in_is_m) begin
         load_hold = 1'b1;
      end
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      hold_d   = hold_q;
      if (ex_flush_i) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         hold_d   = '0;
      end else begin
         if (accept) begin
            wr_ptr_d = wr_ptr_inc;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_inc;
         end
         case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (load_hold) begin
            hold_d = HOLD_LOAD;
         end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
         end
      end
      state_d = state_of(count_d);
      ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
         ready_q  <= ready_d;
      end
   end

   // Payload storage needs no reset: every read of it is gated by count.
   always_ff @(posedge clk_i) begin
      if (accept && !ex_flush_i) begin
         mem_q[wr_ptr_q] <= '{pc: fd_pc_i, instr: fd_instr_i};
      end
   end

   assign FD_pipeready_o = ready_q;
   assign ex_valid_o     = valid_int;
   assign ex_pc_o        = (state_q != ST_EMPTY) ? head.pc    : 32'h0;
   assign ex_instr_o     = (state_q != ST_EMPTY) ? head.instr : 32'h0;

endmodule

// File: tb/tb_ex_issue_buffer.sv
// Self-checking bench for ex_issue_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_ex_issue_buffer;

   localparam int DEPTH    = 2;
   localparam int MDIV_LAT = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] MUL = 32'h02B5_0533;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        fd_valid_i = 1'b0;
   logic [31:0] fd_pc_i = '0;
   logic [31:0] fd_instr_i = '0;
   logic        FD_pipeready_o;
   logic        ex_flush_i = 1'b0;
   logic        ex_ready_i = 1'b0;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_instr_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_pc[$];
   logic [31:0] m_ins[$];
   int          hold_m = 0;
   logic        rdy_m = 1'b0;
   logic [31:0] dut_pops[$];

   ex_issue_buffer #(.DEPTH(DEPTH), .MDIV_LAT(MDIV_LAT)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .fd_valid_i(fd_valid_i), .fd_pc_i(fd_pc_i), .fd_instr_i(fd_instr_i),
      .FD_pipeready_o(FD_pipeready_o), .ex_flush_i(ex_flush_i),
      .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
      .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic bit tb_is_m(input logic [31:0] i);
      return (i[6:0] == 7'h33) && (i[31:25] == 7'h01);
   endfunction

   function automatic logic [65:0] model_out();
      logic v;
      v = (m_pc.size() != 0) && (hold_m == 0);
      if (m_pc.size() == 0) return {rdy_m, 1'b0, 64'h0};
      return {rdy_m, v, m_pc[0], m_ins[0]};
   endfunction

   function automatic logic [65:0] dut_out();
      return {FD_pipeready_o, ex_valid_o, ex_pc_o, ex_instr_o};
   endfunction

   task automatic model_reset();
      m_pc.delete();
      m_ins.delete();
      hold_m = 0;
      rdy_m  = 1'b0;
   endtask

   // One clock: apply inputs, step the model across the edge, settle 1 time unit.
   task automatic drive_cycle(input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic er,
                              input logic fl);
      bit acc, pop, was_empty;
      fd_valid_i = v;
      fd_pc_i    = pc;
      fd_instr_i = ins;
      ex_ready_i = er;
      ex_flush_i = fl;
      acc = v && rdy_m;
      pop = (m_pc.size() != 0) && (hold_m == 0) && er;
      if (ex_valid_o && er && !fl) dut_pops.push_back(ex_pc_o);
      @(posedge clk_i);
      if (fl) begin
         m_pc.delete();
         m_ins.delete();
         hold_m = 0;
      end else begin
         was_empty = (m_pc.size() == 0);
         if (pop) begin
            void'(m_pc.pop_front());
            void'(m_ins.pop_front());
         end
         if (acc) begin
            m_pc.push_back(pc);
            m_ins.push_back(ins);
         end
         if ((pop || (acc && was_empty)) && m_pc.size() != 0 && tb_is_m(m_ins[0]))
            hold_m = MDIV_LAT - 1;
         else if (hold_m > 0)
            hold_m--;
      end
      rdy_m = (m_pc.size() != DEPTH);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH * MDIV_LAT + 4; i++) begin
         drive_cycle(1'b0, 32'h0, NOP, 1'b1, 1'b0);
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %h expected %h", tag, dut_out(), model_out());
         end
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      model_reset();
      fd_valid_i = 1'b1; fd_pc_i = 32'h0; fd_instr_i = NOP; ex_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (dut_out() !== 66'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", dut_out(), 66'h0);
      end
      reset_i = 1'b0;
      drive_cycle(1'b1, 32'h0, NOP, 1'b1, 1'b0);
      checks++;
      if (FD_pipeready_o !== 1'b1 || ex_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got rdy=%b vld=%b expected rdy=1 vld=0", FD_pipeready_o, ex_valid_o);
      end
      drive_cycle(1'b1, 32'h0, NOP, 1'b1, 1'b0);
      checks++;
      if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_first_accept: got vld=%b pc=%h expected vld=1 pc=0", ex_valid_o, ex_pc_o);
      end
      drain("reset");
   endtask

   task automatic test_stream();
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b1, 32'(4 * k), NOP, 1'b1, 1'b0);
         checks++;
         if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'(4 * k) || dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL stream_k%0d: got %h expected pc %h model %h", k, dut_out(), 32'(4 * k), model_out());
         end
      end
      drain("stream");
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int accepts = 0;
      bit acc;
      dut_pops.delete();
      for (int c = 0; c < 4; c++) begin
         acc = (idx < 3) && FD_pipeready_o;
         drive_cycle(idx < 3, 32'(4 * idx), NOP, 1'b0, 1'b0);
         if (acc) begin idx++; accepts++; end
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL bp_fill_c%0d: got %h expected %h", c, dut_out(), model_out());
         end
      end
      checks++;
      if (accepts != 2 || FD_pipeready_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_full: got accepts=%0d rdy=%b expected accepts=2 rdy=0", accepts, FD_pipeready_o);
      end
      for (int c = 0; c < 8; c++) begin
         acc = (idx < 3) && FD_pipeready_o;
         drive_cycle(idx < 3, 32'(4 * idx), NOP, 1'b1, 1'b0);
         if (acc) idx++;
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL bp_drain_c%0d: got %h expected %h", c, dut_out(), model_out());
         end
      end
      checks++;
      if (dut_pops.size() != 3 || dut_pops[0] !== 32'h0 || dut_pops[1] !== 32'h4 || dut_pops[2] !== 32'h8) begin
         errors++;
         $display("[TB] FAIL bp_order: got %0d pops first=%h expected 3 pops 0,4,8",
                  dut_pops.size(), (dut_pops.size() != 0) ? dut_pops[0] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_muldiv();
      logic        ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] ep [6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h14, 32'h0};
      for (int c = 0; c < 6; c++) begin
         if (c == 0)      drive_cycle(1'b1, 32'h10, MUL, 1'b1, 1'b0);
         else if (c == 1) drive_cycle(1'b1, 32'h14, NOP, 1'b1, 1'b0);
         else             drive_cycle(1'b0, 32'h0,  NOP, 1'b1, 1'b0);
         checks++;
         if (ex_valid_o !== ev[c] || ex_pc_o !== ep[c] || dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL muldiv_c%0d: got vld=%b pc=%h expected vld=%b pc=%h", c, ex_valid_o, ex_pc_o, ev[c], ep[c]);
         end
      end
      drain("muldiv");
   endtask

   task automatic test_flush();
      drive_cycle(1'b1, 32'h20, NOP, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h24, NOP, 1'b0, 1'b0);
      checks++;
      if (FD_pipeready_o !== 1'b0 || dut_out() !== model_out()) begin
         errors++;
         $display("[TB] FAIL flush_fill: got %h expected %h", dut_out(), model_out());
      end
      drive_cycle(1'b1, 32'h2C, NOP, 1'b0, 1'b1);
      checks++;
      if (ex_valid_o !== 1'b0 || FD_pipeready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_full: got vld=%b rdy=%b expected vld=0 rdy=1", ex_valid_o, FD_pipeready_o);
      end
      drive_cycle(1'b1, 32'h30, NOP, 1'b1, 1'b0);
      drive_cycle(1'b1, 32'h34, NOP, 1'b1, 1'b1);
      checks++;
      if (ex_valid_o !== 1'b0 || FD_pipeready_o !== 1'b1 || dut_out() !== model_out()) begin
         errors++;
         $display("[TB] FAIL flush_acc_pop: got %h expected %h", dut_out(), model_out());
      end
      dut_pops.delete();
      drive_cycle(1'b1, 32'h40, NOP, 1'b1, 1'b0);
      checks++;
      if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h40) begin
         errors++;
         $display("[TB] FAIL flush_next: got vld=%b pc=%h expected vld=1 pc=00000040", ex_valid_o, ex_pc_o);
      end
      drain("flush");
      checks++;
      if (dut_pops.size() != 1 || dut_pops[0] !== 32'h40) begin
         errors++;
         $display("[TB] FAIL flush_pops: got %0d pops expected exactly 0x40", dut_pops.size());
      end
   endtask

   task automatic test_reset_mid_hold();
      drive_cycle(1'b1, 32'h50, MUL, 1'b1, 1'b0);
      drive_cycle(1'b0, 32'h0, NOP, 1'b1, 1'b0);
      #2;
      reset_i = 1'b1;
      #1;
      checks++;
      if (dut_out() !== 66'h0) begin
         errors++;
         $display("[TB] FAIL midhold_async_reset: got %h expected %h", dut_out(), 66'h0);
      end
      model_reset();
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      drive_cycle(1'b1, 32'h80, NOP, 1'b1, 1'b0);
      drive_cycle(1'b1, 32'h80, NOP, 1'b1, 1'b0);
      checks++;
      if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h80 || dut_out() !== model_out()) begin
         errors++;
         $display("[TB] FAIL midhold_resume: got vld=%b pc=%h expected vld=1 pc=00000080", ex_valid_o, ex_pc_o);
      end
      drive_cycle(1'b0, 32'h0, NOP, 1'b1, 1'b0);
      checks++;
      if (ex_valid_o !== 1'b0 || dut_out() !== model_out()) begin
         errors++;
         $display("[TB] FAIL midhold_no_stale: got %h expected %h", dut_out(), model_out());
      end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [31:0] pc = 32'h1000;
      for (int c = 0; c < 400; c++) begin
         ins = $urandom;
         if ($urandom_range(0, 3) == 0) ins = {7'h01, ins[24:7], 7'h33};
         drive_cycle(1'($urandom_range(0, 3) != 0), pc, ins,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
         pc = pc + 32'h4;
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("[TB] FAIL random_c%0d: got %h expected %h", c, dut_out(), model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      drain("bp");
      test_muldiv();
      test_flush();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
